// File: rtl/btb_controller.sv
// btb_controller: branch target buffer with per-entry 2-bit predictors, a 2-deep
// resolved-branch update queue, and an invalidate sweep after reset and on flush.
module btb_controller #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_mispredicted,
    input  logic        flush_all,
    output logic        init_busy,
    output logic [15:0] mispredict_count
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    localparam logic [1:0] ST_SNT = 2'd0;
    localparam logic [1:0] ST_WNT = 2'd1;
    localparam logic [1:0] ST_WT  = 2'd2;
    localparam logic [1:0] ST_ST  = 2'd3;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } mode_e;

    function automatic logic [1:0] next_state(input logic [1:0] s, input logic m);
        logic [1:0] n;
        case (s)
            ST_SNT:  n = m ? ST_WNT : ST_SNT;
            ST_WNT:  n = m ? ST_ST  : ST_SNT;
            ST_ST:   n = m ? ST_WT  : ST_ST;
            ST_WT:   n = m ? ST_SNT : ST_ST;
            default: n = s;
        endcase
        return n;
    endfunction

    mode_e                  mode_q, mode_d;
    logic [INDEX_BITS-1:0]  init_idx_q, init_idx_d;
    logic [31:0]            q_pc_q     [2];
    logic [31:0]            q_target_q [2];
    logic                   q_taken_q  [2];
    logic                   q_mis_q    [2];
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
    logic [15:0]            mis_cnt_q;
    logic [ENTRIES-1:0]     valid_q;
    logic [TAG_BITS-1:0]    tag_q    [ENTRIES];
    logic [31:0]            target_q [ENTRIES];
    logic [1:0]             state_q  [ENTRIES];

    logic                   run_s, push_s, pop_s;
    logic [31:0]            head_pc_s, head_target_s;
    logic                   head_taken_s, head_mis_s, head_hit_s;
    logic [INDEX_BITS-1:0]  head_idx_s, lk_idx_s;
    logic [TAG_BITS-1:0]    head_tag_s, lk_tag_s;
    logic                   alloc_s, state_we_s, target_we_s;
    logic [1:0]             new_state_s;

    assign run_s     = (mode_q == S_RUN);
    assign init_busy = ~run_s;
    // A flush cycle refuses the update so the handshake never reports a dropped transfer.
    assign upd_ready = run_s && (count_q != 2'd2) && !flush_all;
    assign push_s    = upd_valid && upd_ready;
    assign pop_s     = run_s && !flush_all && (count_q != 2'd0);
    assign mispredict_count = mis_cnt_q;

    assign head_pc_s     = q_pc_q[rd_ptr_q];
    assign head_target_s = q_target_q[rd_ptr_q];
    assign head_taken_s  = q_taken_q[rd_ptr_q];
    assign head_mis_s    = q_mis_q[rd_ptr_q];
    assign head_idx_s    = head_pc_s[INDEX_BITS+1:2];
    assign head_tag_s    = head_pc_s[31:INDEX_BITS+2];
    assign lk_idx_s      = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag_s      = lookup_pc[31:INDEX_BITS+2];

    // Controller mode and sweep index next-state.
    always_comb begin
        mode_d     = mode_q;
        init_idx_d = init_idx_q;
        case (mode_q)
            S_INIT: begin
                if (init_idx_q == INDEX_BITS'(ENTRIES - 1)) begin
                    mode_d     = S_RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + INDEX_BITS'(1);
                end
            end
            S_RUN: begin
                if (flush_all) begin
                    mode_d     = S_INIT;
                    init_idx_d = '0;
                end else begin
                    mode_d = S_RUN;
                end
            end
            default: begin
                mode_d     = S_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // Update-queue pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (run_s && flush_all) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Head-of-queue table write decode.
    always_comb begin
        head_hit_s  = valid_q[head_idx_s] && (tag_q[head_idx_s] == head_tag_s);
        alloc_s     = 1'b0;
        state_we_s  = 1'b0;
        target_we_s = 1'b0;
        new_state_s = ST_WT;
        if (pop_s) begin
            if (head_hit_s) begin
                state_we_s  = 1'b1;
                target_we_s = head_taken_s;
                new_state_s = next_state(state_q[head_idx_s], head_mis_s);
            end else begin
                alloc_s     = head_taken_s;
                state_we_s  = head_taken_s;
                target_we_s = head_taken_s;
                new_state_s = ST_WT;
            end
        end else begin
            new_state_s = ST_WT;
        end
    end

    // Combinational lookup; nothing is reported while the table is being swept.
    always_comb begin
        lookup_hit     = 1'b0;
        predict_taken  = 1'b0;
        predict_target = 32'd0;
        if (run_s && valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s)) begin
            lookup_hit     = 1'b1;
            predict_taken  = (state_q[lk_idx_s] == ST_WT) || (state_q[lk_idx_s] == ST_ST);
            predict_target = target_q[lk_idx_s];
        end else begin
            lookup_hit = 1'b0;
        end
    end

    // Mode, sweep index and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= S_INIT;
            init_idx_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            mode_q     <= mode_d;
            init_idx_q <= init_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]     <= 32'd0;
                q_target_q[i] <= 32'd0;
                q_taken_q[i]  <= 1'b0;
                q_mis_q[i]    <= 1'b0;
            end
        end else if (push_s) begin
            q_pc_q[wr_ptr_q]     <= upd_pc;
            q_target_q[wr_ptr_q] <= upd_target;
            q_taken_q[wr_ptr_q]  <= upd_taken;
            q_mis_q[wr_ptr_q]    <= upd_mispredicted;
        end
    end

    // Saturating mispredict counter; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_cnt_q <= 16'd0;
        end else if (push_s && upd_mispredicted && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    // Valid bits: cleared by the sweep, set on allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (!run_s) begin
            valid_q[init_idx_q] <= 1'b0;
        end else if (alloc_s) begin
            valid_q[head_idx_s] <= 1'b1;
        end
    end

    // Tag, target and predictor storage; contents only meaningful under valid.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            tag_q[head_idx_s] <= head_tag_s;
        end
        if (target_we_s) begin
            target_q[head_idx_s] <= head_target_s;
        end
        if (state_we_s) begin
            state_q[head_idx_s] <= new_state_s;
        end
    end

endmodule

// File: tb/tb_btb_controller.sv
// Self-checking bench for btb_controller: directed scenarios plus random traffic,
// compared every cycle against a queue/array reference model.
module tb_btb_controller;

    localparam int N   = 16;
    localparam int SNT = 0;
    localparam int WNT = 1;
    localparam int WT  = 2;
    localparam int STK = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        lookup_hit, predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid, upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken, upd_mispredicted, flush_all;
    logic        init_busy;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    btb_controller #(.ENTRIES(N), .INDEX_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .lookup_hit(lookup_hit), .predict_taken(predict_taken),
        .predict_target(predict_target), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_mispredicted(upd_mispredicted),
        .flush_all(flush_all), .init_busy(init_busy),
        .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          tk;
        bit          mp;
    } upd_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_run;
    int          m_sweep;
    bit          m_v   [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_st  [N];
    int          m_cnt;
    upd_t        m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int s, input bit m);
        case (s)
            SNT:     return m ? WNT : SNT;
            WNT:     return m ? STK : SNT;
            STK:     return m ? WT  : STK;
            WT:      return m ? SNT : STK;
            default: return s;
        endcase
    endfunction

    function automatic bit exp_ready();
        return rst_n && m_run && (m_q.size() < 2) && !flush_all;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_sweep = 0;
        m_cnt   = 0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_apply(input upd_t h);
        int i;
        logic [31:0] t;
        i = int'((h.pc / 4) % N);
        t = h.pc / (4 * N);
        if (m_v[i] && m_tag[i] == t) begin
            m_st[i] = nxt(m_st[i], h.mp);
            if (h.tk) m_tgt[i] = h.tgt;
        end else if (h.tk) begin
            m_v[i]   = 1'b1;
            m_tag[i] = t;
            m_tgt[i] = h.tgt;
            m_st[i]  = WT;
        end
    endtask

    task automatic check_outputs();
        int i;
        bit hit;
        i   = int'((lookup_pc / 4) % N);
        hit = m_run && m_v[i] && (m_tag[i] == lookup_pc / (4 * N));
        chk("lookup_hit", {31'd0, lookup_hit}, {31'd0, hit});
        chk("predict_taken", {31'd0, predict_taken},
            {31'd0, hit && (m_st[i] == WT || m_st[i] == STK)});
        chk("predict_target", predict_target, hit ? m_tgt[i] : 32'd0);
        chk("init_busy", {31'd0, init_busy}, {31'd0, !m_run});
        chk("upd_ready", {31'd0, upd_ready}, {31'd0, exp_ready()});
        chk("mispredict_count", {16'd0, mispredict_count}, m_cnt);
    endtask

    // One clock: check at mid-cycle, advance the model at the edge, return at edge+1.
    task automatic step();
        bit   acc;
        upd_t cur;
        #3;
        check_outputs();
        acc = upd_valid && exp_ready();
        cur = '{pc: upd_pc, tgt: upd_target, tk: upd_taken, mp: upd_mispredicted};
        @(posedge clk);
        if (rst_n) begin
            if (acc && cur.mp && m_cnt < 65535) m_cnt++;
            if (!m_run) begin
                m_v[m_sweep] = 1'b0;
                m_sweep++;
                if (m_sweep == N) begin
                    m_run   = 1'b1;
                    m_sweep = 0;
                end
            end else if (flush_all) begin
                m_q.delete();
                m_run   = 1'b0;
                m_sweep = 0;
            end else begin
                if (m_q.size() > 0) model_apply(m_q.pop_front());
                if (acc) m_q.push_back(cur);
            end
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Present one update for a cycle, then idle one cycle so it is written and visible.
    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit mp);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_mispredicted = mp;
        step();
        upd_valid = 1'b0;
        step();
        lookup_pc = pc;
    endtask

    bit          wk_tk [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit          wk_mp [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit          wk_pt [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; lookup_pc = 32'h0000_0100; upd_valid = 1'b0; upd_pc = 32'd0;
        upd_target = 32'd0; upd_taken = 1'b0; upd_mispredicted = 1'b0; flush_all = 1'b0;
        model_reset();
        steps(2);
        rst_n = 1'b1;
        // Sweep: model expects init_busy for N cycles, upd_ready in cycle N.
        for (int k = 0; k < N + 2; k++) begin
            lookup_pc = $urandom & 32'hFFFF_FFFC;
            step();
        end
        lookup_pc = 32'h0000_0100;
        #2;
        chk("sweep_done_ready", {31'd0, upd_ready}, 32'd1);

        do_upd(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1);
        #2;
        chk("alloc_hit", {31'd0, lookup_hit}, 32'd1);
        chk("alloc_taken", {31'd0, predict_taken}, 32'd1);
        chk("alloc_target", predict_target, 32'h0000_0200);
        chk("alloc_mcount", {16'd0, mispredict_count}, 32'd1);
        step();

        for (int k = 0; k < 9; k++) begin
            do_upd(32'h0000_0100, 32'h0000_0204 + 32'(k * 4), wk_tk[k], wk_mp[k]);
            #2;
            chk("walk_taken", {31'd0, predict_taken}, {31'd0, wk_pt[k]});
            step();
        end

        do_upd(32'h0000_0140, 32'h0000_0300, 1'b1, 1'b0);
        lookup_pc = 32'h0000_0100;
        #2;
        chk("conflict_old_miss", {31'd0, lookup_hit}, 32'd0);
        lookup_pc = 32'h0000_0140;
        #1;
        chk("conflict_new_hit", {31'd0, lookup_hit}, 32'd1);
        chk("conflict_new_target", predict_target, 32'h0000_0300);
        step();
        do_upd(32'h0000_0500, 32'h0000_0600, 1'b0, 1'b0);
        #2;
        chk("nottaken_no_alloc", {31'd0, lookup_hit}, 32'd0);
        step();

        // Pending update discarded by flush; the flush-cycle update is refused.
        upd_valid = 1'b1; upd_pc = 32'h0000_0180; upd_target = 32'h0000_0700;
        upd_taken = 1'b1; upd_mispredicted = 1'b1;
        step();
        flush_all = 1'b1;
        step();
        flush_all = 1'b0; upd_valid = 1'b0;
        steps(N + 1);
        lookup_pc = 32'h0000_0180;
        #2;
        chk("flush_discard", {31'd0, lookup_hit}, 32'd0);
        lookup_pc = 32'h0000_0140;
        #1;
        chk("flush_cleared", {31'd0, lookup_hit}, 32'd0);
        step();

        // Backpressure: valid held high straight through a flush-induced sweep.
        upd_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            upd_pc = 32'((($urandom % 4) * N + ($urandom % N)) * 4);
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_taken = 1'($urandom); upd_mispredicted = 1'($urandom);
            lookup_pc = upd_pc;
            flush_all = (k == 6);
            step();
        end
        flush_all = 1'b0;

        for (int k = 0; k < 400; k++) begin
            upd_valid = ($urandom % 2) == 0;
            upd_pc = 32'((($urandom % 4) * N + ($urandom % N)) * 4);
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_taken = 1'($urandom); upd_mispredicted = 1'($urandom);
            lookup_pc = 32'((($urandom % 4) * N + ($urandom % N)) * 4);
            flush_all = ($urandom % 50) == 0;
            step();
        end
        flush_all = 1'b0; upd_valid = 1'b0;
        steps(N + 2);

        // Asynchronous reset in the middle of traffic.
        upd_valid = 1'b1;
        step();
        rst_n = 1'b0;
        model_reset();
        steps(2);
        rst_n = 1'b1; upd_valid = 1'b0;
        steps(N + 1);

        // Saturation of the mispredict counter.
        upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_target = 32'h0000_0200;
        upd_taken = 1'b1; upd_mispredicted = 1'b1; lookup_pc = 32'h0000_0100;
        steps(65540);
        upd_valid = 1'b0;
        #2;
        chk("mcount_saturated", {16'd0, mispredict_count}, 32'h0000_FFFF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
